// File: rtl/perf_console_mmio.sv
// Memory-mapped console UART with FIFO, end-of-run detection and 64-bit
// cycle/retire/branch performance counters readable over the I/O window.
module perf_console_mmio #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [31:0] FINI_CODE    = 32'h0002_0000
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        wvalid_i,
   input  logic [31:0] waddr_i,
   input  logic [31:0] wdata_i,
   input  logic        rd_en_i,
   input  logic [31:0] raddr_i,
   output logic [31:0] rdata_o,
   input  logic        ev_retire_i,
   input  logic        ev_ctrl_i,
   input  logic        ev_misp_i,
   output logic        busy_o,
   output logic        uart_tx_o,
   output logic        fini_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} run_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   run_state_t      run_state;
   tx_state_t       tx_state;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            ovf;
   logic [CW-1:0]   tx_cnt;
   logic [2:0]      tx_bit;
   logic [7:0]      tx_shift;
   logic            tx_line;
   logic [63:0]     mcycle, minstret, brpred, brmisp;
   logic [31:0]     shadow;

   logic con_wr, fini_wr, push_req, push, pop, ovf_set;
   logic fifo_empty, fifo_full, bit_end, tx_busy;
   logic unused_addr_bits;

   assign con_wr     = wvalid_i & waddr_i[31] & (waddr_i[5:2] == 4'd0);
   assign fini_wr    = con_wr & (wdata_i == FINI_CODE) & (run_state == RUN);
   assign push_req   = con_wr & (wdata_i != FINI_CODE) & (run_state == RUN);
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
   assign bit_end    = (tx_cnt == CW'(CLKS_PER_BIT - 1));
   assign tx_busy    = (tx_state != TX_IDLE);
   // Popping at the end of a stop bit lets the next start bit follow with no gap.
   assign pop        = ~fifo_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & bit_end));
   assign push       = push_req & (~fifo_full | pop);
   assign ovf_set    = push_req & fifo_full & ~pop;

   assign busy_o    = fifo_full;
   assign uart_tx_o = tx_line;
   assign fini_o    = (run_state == DONE);

   assign unused_addr_bits = &{1'b0, waddr_i[30:6], waddr_i[1:0], raddr_i[30:6], raddr_i[1:0]};

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= wdata_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (ovf_set) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         run_state <= RUN;
         mcycle    <= '0;
         minstret  <= '0;
         brpred    <= '0;
         brmisp    <= '0;
      end else begin
         case (run_state)
            RUN: begin
               mcycle <= mcycle + 64'd1;
               if (ev_retire_i)            minstret <= minstret + 64'd1;
               if (ev_ctrl_i)              brpred   <= brpred + 64'd1;
               if (ev_ctrl_i && ev_misp_i) brmisp   <= brmisp + 64'd1;
               if (fini_wr)                run_state <= DRAIN;
            end
            DRAIN:   if (fifo_empty && !tx_busy) run_state <= DONE;
            default: run_state <= DONE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (pop)                                tx_shift <= mem[rd_ptr];
      else if (tx_state == TX_DATA && bit_end) tx_shift <= tx_shift >> 1;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_line  <= 1'b1;
      end else begin
         tx_cnt <= bit_end ? '0 : tx_cnt + CW'(1);
         case (tx_state)
            TX_IDLE: begin
               tx_cnt <= '0;
               if (pop) begin
                  tx_state <= TX_START;
                  tx_line  <= 1'b0;
               end
            end
            TX_START: if (bit_end) begin
               tx_state <= TX_DATA;
               tx_bit   <= '0;
               tx_line  <= tx_shift[0];
            end
            TX_DATA: if (bit_end) begin
               if (tx_bit == 3'd7) begin
                  tx_state <= TX_STOP;
                  tx_line  <= 1'b1;
               end else begin
                  tx_bit  <= tx_bit + 3'd1;
                  tx_line <= tx_shift[1];
               end
            end
            default: if (bit_end) begin
               if (pop) begin
                  tx_state <= TX_START;
                  tx_line  <= 1'b0;
               end else begin
                  tx_state <= TX_IDLE;
               end
            end
         endcase
      end
   end

   // Lo reads latch the matching hi word so a later hi read is carry-consistent.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rdata_o <= '0;
         shadow  <= '0;
      end else if (rd_en_i && raddr_i[31]) begin
         case (raddr_i[5:2])
            4'd0:  rdata_o <= {28'b0, ovf, fifo_full, fifo_empty, tx_busy};
            4'd4:  begin rdata_o <= mcycle[31:0];   shadow <= mcycle[63:32];   end
            4'd6:  begin rdata_o <= minstret[31:0]; shadow <= minstret[63:32]; end
            4'd8:  begin rdata_o <= brpred[31:0];   shadow <= brpred[63:32];   end
            4'd10: begin rdata_o <= brmisp[31:0];   shadow <= brmisp[63:32];   end
            4'd5, 4'd7, 4'd9, 4'd11: rdata_o <= shadow;
            default: rdata_o <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_perf_console_mmio.sv
// Directed bench for perf_console_mmio: counters, console UART framing,
// overflow, finish/drain, counter snapshot and asynchronous reset.
module tb_perf_console_mmio;

   localparam int C = 4;
   localparam logic [31:0] CON   = 32'h8000_0000;
   localparam logic [31:0] MCY_L = 32'h8000_0010;
   localparam logic [31:0] MCY_H = 32'h8000_0014;
   localparam logic [31:0] MIN_L = 32'h8000_0018;
   localparam logic [31:0] MIN_H = 32'h8000_001C;
   localparam logic [31:0] BRP_L = 32'h8000_0020;
   localparam logic [31:0] BRP_H = 32'h8000_0024;
   localparam logic [31:0] BRM_L = 32'h8000_0028;
   localparam logic [31:0] FINI  = 32'h0002_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wvalid = 1'b0;
   logic [31:0] waddr = '0;
   logic [31:0] wdata = '0;
   logic        rd_en = 1'b0;
   logic [31:0] raddr = '0;
   logic [31:0] rdata;
   logic        ev_retire = 1'b0, ev_ctrl = 1'b0, ev_misp = 1'b0;
   logic        busy, uart, fini;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // UART receive monitor state
   logic [7:0] rx_bytes[$];
   int         rx_starts[$];
   int         stop_err = 0;
   logic       rx_busy = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh = '0;

   perf_console_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(16), .FINI_CODE(FINI)) dut (
      .clk_i(clk), .rst_n(rst_n), .wvalid_i(wvalid), .waddr_i(waddr), .wdata_i(wdata),
      .rd_en_i(rd_en), .raddr_i(raddr), .rdata_o(rdata), .ev_retire_i(ev_retire),
      .ev_ctrl_i(ev_ctrl), .ev_misp_i(ev_misp), .busy_o(busy), .uart_tx_o(uart),
      .fini_o(fini)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (uart === 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
            rx_sh   = '0;
            rx_starts.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt >= C + C/2 && rx_cnt < 9*C && (rx_cnt % C) == C/2)
            rx_sh = {uart, rx_sh[7:1]};
         if (rx_cnt == 9*C + C/2) begin
            if (uart !== 1'b1) stop_err++;
            rx_bytes.push_back(rx_sh);
            rx_busy = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wvalid = 1'b0; rd_en = 1'b0;
      ev_retire = 1'b0; ev_ctrl = 1'b0; ev_misp = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rx_bytes.delete(); rx_starts.delete(); stop_err = 0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      wvalid = 1'b1; waddr = a; wdata = d;
      tick();
      wvalid = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      rd_en = 1'b1; raddr = a;
      tick();
      rd_en = 1'b0;
      d = rdata;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (uart !== 1'b1) begin n_fail++; $display("FAIL reset_uart got=%b exp=1", uart); end
      n_cmp++; if (fini !== 1'b0) begin n_fail++; $display("FAIL reset_fini got=%b exp=0", fini); end
   endtask

   task automatic test_counters();
      logic [31:0] d, d2;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         ev_retire = (i % 2 == 0);
         tick();
      end
      ev_retire = 1'b0;
      do_read(MIN_L, d);
      n_cmp++; if (d !== 32'd50) begin n_fail++; $display("FAIL minstret_lo got=%0d exp=50", d); end
      do_read(MCY_L, d);
      n_cmp++; if (d !== 32'd101) begin n_fail++; $display("FAIL mcycle_lo got=%0d exp=101", d); end
      do_read(MCY_L, d2);
      n_cmp++; if (d2 !== 32'd102) begin n_fail++; $display("FAIL mcycle_lo2 got=%0d exp=102", d2); end
      for (int i = 0; i < 10; i++) begin
         ev_ctrl = 1'b1; ev_misp = (i < 3);
         tick();
      end
      ev_ctrl = 1'b0;
      repeat (4) tick();
      ev_misp = 1'b0;
      do_read(BRP_L, d);
      n_cmp++; if (d !== 32'd10) begin n_fail++; $display("FAIL brpred_lo got=%0d exp=10", d); end
      do_read(BRM_L, d);
      n_cmp++; if (d !== 32'd3) begin n_fail++; $display("FAIL brmisp_lo got=%0d exp=3", d); end
      do_read(BRP_H, d);
      n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL brpred_hi got=%0d exp=0", d); end
   endtask

   task automatic test_decode();
      logic [31:0] d;
      do_reset();
      do_store(32'h0000_0000, 32'h41);
      do_store(32'h8000_0004, 32'h42);
      do_read(CON, d);
      n_cmp++; if (d !== 32'h2) begin n_fail++; $display("FAIL decode_status got=%h exp=2", d); end
      do_read(32'h8000_0008, d);
      n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_08 got=%h exp=0", d); end
      do_read(32'h8000_0030, d);
      n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_30 got=%h exp=0", d); end
      do_read(32'hC000_0050, d);
      n_cmp++; if (d !== 32'd5) begin n_fail++; $display("FAIL alias_mcycle got=%0d exp=5", d); end
      do_read(32'h0000_0010, d);
      n_cmp++; if (d !== 32'd5) begin n_fail++; $display("FAIL rdata_hold got=%0d exp=5", d); end
   endtask

   task automatic test_console();
      logic [31:0] d;
      int t0;
      do_reset();
      do_store(CON, 32'h48);
      do_store(CON, 32'h69);
      t0 = cyc;
      do_read(CON, d);
      n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL console_status got=%h exp=1", d); end
      for (int i = 0; i < 200 && rx_bytes.size() < 2; i++) tick();
      n_cmp++; if (rx_bytes.size() != 2) begin n_fail++; $display("FAIL console_frames got=%0d exp=2", rx_bytes.size()); end
      else begin
         n_cmp++; if (rx_bytes[0] !== 8'h48) begin n_fail++; $display("FAIL byte0 got=%h exp=48", rx_bytes[0]); end
         n_cmp++; if (rx_bytes[1] !== 8'h69) begin n_fail++; $display("FAIL byte1 got=%h exp=69", rx_bytes[1]); end
         n_cmp++; if (rx_starts[0] != t0) begin n_fail++; $display("FAIL start_cycle got=%0d exp=%0d", rx_starts[0], t0); end
         n_cmp++; if (rx_starts[1] - rx_starts[0] != 10*C) begin n_fail++; $display("FAIL frame_gap got=%0d exp=%0d", rx_starts[1] - rx_starts[0], 10*C); end
      end
      n_cmp++; if (stop_err != 0) begin n_fail++; $display("FAIL stop_bits got=%0d exp=0", stop_err); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      int bad;
      do_reset();
      for (int i = 0; i < 20; i++) do_store(CON, 32'h30 + i);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy got=%b exp=1", busy); end
      do_read(CON, d);
      n_cmp++; if (d !== 32'hD) begin n_fail++; $display("FAIL ovf_status got=%h exp=d", d); end
      for (int i = 0; i < 1000 && rx_bytes.size() < 17; i++) tick();
      repeat (100) tick();
      n_cmp++; if (rx_bytes.size() != 17) begin n_fail++; $display("FAIL ovf_frames got=%0d exp=17", rx_bytes.size()); end
      bad = 0;
      for (int k = 0; k < rx_bytes.size() && k < 17; k++) begin
         if (rx_bytes[k] !== 8'(32'h30 + k)) bad++;
         if (k > 0 && rx_starts[k] - rx_starts[k-1] != 10*C) bad++;
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL ovf_sequence got=%0d errors exp=0", bad); end
      do_read(CON, d);
      n_cmp++; if (d !== 32'hA) begin n_fail++; $display("FAIL ovf_sticky got=%h exp=a", d); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_clear got=%b exp=0", busy); end
   endtask

   task automatic test_finish();
      logic [31:0] d;
      int t0, rise;
      do_reset();
      ev_retire = 1'b1; ev_ctrl = 1'b1;
      do_store(CON, 32'h41);
      do_store(CON, FINI);
      t0 = cyc;
      rise = -1;
      for (int i = 0; i < 100 && rise < 0; i++) begin
         tick();
         if (fini === 1'b1) rise = cyc;
      end
      n_cmp++; if (rise != t0 + 10*C + 1) begin n_fail++; $display("FAIL fini_rise got=%0d exp=%0d", rise, t0 + 10*C + 1); end
      n_cmp++; if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'h41) begin n_fail++; $display("FAIL fini_byte got_n=%0d exp_n=1 (41)", rx_bytes.size()); end
      do_store(CON, 32'h42);
      repeat (10) tick();
      do_read(MIN_L, d);
      n_cmp++; if (d !== 32'd2) begin n_fail++; $display("FAIL fini_minstret got=%0d exp=2", d); end
      do_read(MCY_L, d);
      n_cmp++; if (d !== 32'd2) begin n_fail++; $display("FAIL fini_mcycle got=%0d exp=2", d); end
      do_read(BRP_L, d);
      n_cmp++; if (d !== 32'd2) begin n_fail++; $display("FAIL fini_brpred got=%0d exp=2", d); end
      repeat (60) tick();
      n_cmp++; if (rx_bytes.size() != 1) begin n_fail++; $display("FAIL done_write_ignored got=%0d frames exp=1", rx_bytes.size()); end
      n_cmp++; if (fini !== 1'b1) begin n_fail++; $display("FAIL fini_hold got=%b exp=1", fini); end
      ev_retire = 1'b0; ev_ctrl = 1'b0;
   endtask

   task automatic test_snapshot();
      logic [31:0] d;
      do_reset();
      repeat (2) tick();
      force dut.mcycle = 64'h0000_0000_FFFF_FFFD;
      #1 release dut.mcycle;
      do_read(MCY_L, d);
      n_cmp++; if (d !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL snap_lo got=%h exp=fffffffd", d); end
      repeat (3) tick();
      do_read(MCY_H, d);
      n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL snap_hi got=%h exp=0", d); end
      do_read(MCY_L, d);
      n_cmp++; if (d !== 32'h2) begin n_fail++; $display("FAIL snap_lo2 got=%h exp=2", d); end
      do_read(MCY_H, d);
      n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL snap_hi2 got=%h exp=1", d); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      do_reset();
      do_store(CON, 32'h00);
      do_store(CON, 32'h00);
      do_read(MCY_L, d);
      n_cmp++; if (d !== 32'd2) begin n_fail++; $display("FAIL mid_mcycle got=%0d exp=2", d); end
      repeat (14) tick();
      n_cmp++; if (uart !== 1'b0) begin n_fail++; $display("FAIL mid_uart_low got=%b exp=0", uart); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (uart !== 1'b1) begin n_fail++; $display("FAIL async_uart got=%b exp=1", uart); end
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL async_rdata got=%h exp=0", rdata); end
      n_cmp++; if (dut.mcycle !== 64'h0) begin n_fail++; $display("FAIL async_mcycle got=%h exp=0", dut.mcycle); end
      n_cmp++; if (dut.minstret !== 64'h0 || dut.brpred !== 64'h0 || dut.brmisp !== 64'h0) begin
         n_fail++; $display("FAIL async_counters got=%h/%h/%h exp=0", dut.minstret, dut.brpred, dut.brmisp);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rx_bytes.delete(); rx_starts.delete();
      do_read(CON, d);
      n_cmp++; if (d !== 32'h2) begin n_fail++; $display("FAIL post_reset_status got=%h exp=2", d); end
      repeat (60) tick();
      n_cmp++; if (rx_bytes.size() != 0) begin n_fail++; $display("FAIL post_reset_frames got=%0d exp=0", rx_bytes.size()); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_counters();
      test_decode();
      test_console();
      test_overflow();
      test_finish();
      test_snapshot();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
